// File: rtl/rename_regfile_if.sv
// Issue, commit, operand-read and ROB-lookup bundle between the issue stage and the rename register file.
// The master side is the issue/commit logic; the slave side is rename_regfile.
interface rename_regfile_if #(
  parameter int XLEN         = 32,
  parameter int REG_NUM      = 32,
  parameter int ENTRY_SIZE   = 4,
  parameter int COMMIT_WIDTH = 2
);
  localparam int RW = $clog2(REG_NUM);

  logic                           rdy_in;
  logic                           roll_back;
  logic                           issue_valid;
  logic [RW-1:0]                  issue_rd;
  logic [ENTRY_SIZE-1:0]          issue_tag;
  logic [COMMIT_WIDTH-1:0]        commit_valid;
  logic [COMMIT_WIDTH*RW-1:0]     commit_rd;
  logic [COMMIT_WIDTH*ENTRY_SIZE-1:0] commit_tag;
  logic [COMMIT_WIDTH*XLEN-1:0]   commit_value;
  logic                           rs1_valid;
  logic                           rs2_valid;
  logic [RW-1:0]                  rs1;
  logic [RW-1:0]                  rs2;
  logic [ENTRY_SIZE-1:0]          rob_q1_tag;
  logic [ENTRY_SIZE-1:0]          rob_q2_tag;
  logic                           rob_q1_ready;
  logic                           rob_q2_ready;
  logic [XLEN-1:0]                rob_q1_value;
  logic [XLEN-1:0]                rob_q2_value;
  logic                           Qj_valid;
  logic                           Qk_valid;
  logic [ENTRY_SIZE-1:0]          Qj;
  logic [ENTRY_SIZE-1:0]          Qk;
  logic [XLEN-1:0]                Vj;
  logic [XLEN-1:0]                Vk;
  logic [63:0]                    instret;

  modport master (
    output rdy_in, roll_back, issue_valid, issue_rd, issue_tag,
           commit_valid, commit_rd, commit_tag, commit_value,
           rs1_valid, rs2_valid, rs1, rs2,
           rob_q1_ready, rob_q2_ready, rob_q1_value, rob_q2_value,
    input  rob_q1_tag, rob_q2_tag, Qj_valid, Qk_valid, Qj, Qk, Vj, Vk, instret
  );

  modport slave (
    input  rdy_in, roll_back, issue_valid, issue_rd, issue_tag,
           commit_valid, commit_rd, commit_tag, commit_value,
           rs1_valid, rs2_valid, rs1, rs2,
           rob_q1_ready, rob_q2_ready, rob_q1_value, rob_q2_value,
    output rob_q1_tag, rob_q2_tag, Qj_valid, Qk_valid, Qj, Qk, Vj, Vk, instret
  );
endinterface

// File: rtl/rename_regfile.sv
// Architectural register file with alias (busy/tag) state for the out-of-order core: multi-lane
// in-order commit, commit-to-read bypass, ROB-ready lookup for busy sources and a retired counter.
module rename_regfile #(
  parameter int XLEN         = 32,
  parameter int REG_NUM      = 32,
  parameter int ENTRY_SIZE   = 4,
  parameter int COMMIT_WIDTH = 2
) (
  input logic             clk,
  input logic             rst_in,
  rename_regfile_if.slave bus
);
  localparam int RW = $clog2(REG_NUM);

  typedef struct packed {
    logic                  qValid;
    logic [ENTRY_SIZE-1:0] q;
    logic [XLEN-1:0]       v;
  } readRes_t;

  logic [XLEN-1:0]       value_q [REG_NUM];
  logic [XLEN-1:0]       value_d [REG_NUM];
  logic [ENTRY_SIZE-1:0] tag_q   [REG_NUM];
  logic [ENTRY_SIZE-1:0] tag_d   [REG_NUM];
  logic [REG_NUM-1:0]    busy_q;
  logic [REG_NUM-1:0]    busy_d;
  logic [63:0]           instret_q;
  logic [63:0]           instret_d;

  logic                  cValid [COMMIT_WIDTH];
  logic [RW-1:0]         cRd    [COMMIT_WIDTH];
  logic [ENTRY_SIZE-1:0] cTag   [COMMIT_WIDTH];
  logic [XLEN-1:0]       cValue [COMMIT_WIDTH];

  readRes_t resJ;
  readRes_t resK;

  always_comb begin
    for (int l = 0; l < COMMIT_WIDTH; l++) begin
      cValid[l] = bus.commit_valid[l];
      cRd[l]    = bus.commit_rd[l*RW +: RW];
      cTag[l]   = bus.commit_tag[l*ENTRY_SIZE +: ENTRY_SIZE];
      cValue[l] = bus.commit_value[l*XLEN +: XLEN];
    end
  end

  // A later lane overwrites an earlier bypass hit, so the youngest matching commit supplies the value.
  function automatic readRes_t readPort(input logic valid, input logic [RW-1:0] idx,
                                        input logic robReady, input logic [XLEN-1:0] robValue);
    readRes_t r;
    logic     hit;
    r   = '0;
    hit = 1'b0;
    if (valid && idx != '0) begin
      for (int l = 0; l < COMMIT_WIDTH; l++) begin
        if (cValid[l] && cRd[l] == idx && busy_q[idx] && tag_q[idx] == cTag[l]) begin
          hit  = 1'b1;
          r.v  = cValue[l];
        end
      end
      if (!hit) begin
        if (busy_q[idx] && robReady) begin
          r.v = robValue;
        end else if (busy_q[idx]) begin
          r.qValid = 1'b1;
          r.q      = tag_q[idx];
        end else begin
          r.v = value_q[idx];
        end
      end
    end
    return r;
  endfunction

  always_comb begin
    resJ = readPort(bus.rs1_valid, bus.rs1, bus.rob_q1_ready, bus.rob_q1_value);
    resK = readPort(bus.rs2_valid, bus.rs2, bus.rob_q2_ready, bus.rob_q2_value);
  end

  assign bus.Qj_valid   = resJ.qValid;
  assign bus.Qj         = resJ.q;
  assign bus.Vj         = resJ.v;
  assign bus.Qk_valid   = resK.qValid;
  assign bus.Qk         = resK.q;
  assign bus.Vk         = resK.v;
  assign bus.rob_q1_tag = tag_q[bus.rs1];
  assign bus.rob_q2_tag = tag_q[bus.rs2];
  assign bus.instret    = instret_q;

  // Lanes are applied oldest first against the evolving next state; issue renames last so it wins.
  always_comb begin
    value_d   = value_q;
    tag_d     = tag_q;
    busy_d    = busy_q;
    instret_d = instret_q;
    if (bus.rdy_in) begin
      for (int l = 0; l < COMMIT_WIDTH; l++) begin
        instret_d = instret_d + {63'd0, cValid[l]};
        if (cValid[l] && cRd[l] != '0) begin
          value_d[cRd[l]] = cValue[l];
          if (busy_d[cRd[l]] && tag_d[cRd[l]] == cTag[l]) begin
            busy_d[cRd[l]] = 1'b0;
            tag_d[cRd[l]]  = '0;
          end
        end
      end
      if (bus.roll_back) begin
        busy_d = '0;
        for (int r = 0; r < REG_NUM; r++) begin
          tag_d[r] = '0;
        end
      end else if (bus.issue_valid && bus.issue_rd != '0) begin
        tag_d[bus.issue_rd]  = bus.issue_tag;
        busy_d[bus.issue_rd] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_in) begin
      for (int r = 0; r < REG_NUM; r++) begin
        value_q[r] <= '0;
        tag_q[r]   <= '0;
      end
      busy_q    <= '0;
      instret_q <= '0;
    end else begin
      value_q   <= value_d;
      tag_q     <= tag_d;
      busy_q    <= busy_d;
      instret_q <= instret_d;
    end
  end
endmodule

// File: tb/tb_rename_regfile.sv
// Directed bench for rename_regfile: inputs change on the falling edge, outputs are checked
// shortly after, and state is committed on the following rising edge.
module tb_rename_regfile;
  localparam int XLEN         = 32;
  localparam int REG_NUM      = 32;
  localparam int ENTRY_SIZE   = 4;
  localparam int COMMIT_WIDTH = 2;
  localparam int RW           = $clog2(REG_NUM);

  logic clk;
  logic rst;
  int   checkCount;
  int   passCount;

  rename_regfile_if #(.XLEN(XLEN), .REG_NUM(REG_NUM), .ENTRY_SIZE(ENTRY_SIZE),
                      .COMMIT_WIDTH(COMMIT_WIDTH)) bus ();

  rename_regfile #(.XLEN(XLEN), .REG_NUM(REG_NUM), .ENTRY_SIZE(ENTRY_SIZE),
                   .COMMIT_WIDTH(COMMIT_WIDTH)) dut (
    .clk    (clk),
    .rst_in (rst),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] observed, input logic [63:0] expected);
    checkCount++;
    if (observed === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, observed, expected);
    end
  endtask

  // Returns every input to its idle value (rdy high, nothing valid).
  task automatic applyStimulus();
    bus.rdy_in       = 1'b1;
    bus.roll_back    = 1'b0;
    bus.issue_valid  = 1'b0;
    bus.issue_rd     = '0;
    bus.issue_tag    = '0;
    bus.commit_valid = '0;
    bus.commit_rd    = '0;
    bus.commit_tag   = '0;
    bus.commit_value = '0;
    bus.rs1_valid    = 1'b0;
    bus.rs2_valid    = 1'b0;
    bus.rs1          = '0;
    bus.rs2          = '0;
    bus.rob_q1_ready = 1'b0;
    bus.rob_q2_ready = 1'b0;
    bus.rob_q1_value = '0;
    bus.rob_q2_value = '0;
  endtask

  task automatic setCommit(input int lane, input logic [RW-1:0] rd,
                           input logic [ENTRY_SIZE-1:0] tag, input logic [XLEN-1:0] val);
    bus.commit_valid[lane]                         = 1'b1;
    bus.commit_rd[lane*RW +: RW]                   = rd;
    bus.commit_tag[lane*ENTRY_SIZE +: ENTRY_SIZE]  = tag;
    bus.commit_value[lane*XLEN +: XLEN]            = val;
  endtask

  task automatic setIssue(input logic [RW-1:0] rd, input logic [ENTRY_SIZE-1:0] tag);
    bus.issue_valid = 1'b1;
    bus.issue_rd    = rd;
    bus.issue_tag   = tag;
  endtask

  task automatic readSrc(input logic [RW-1:0] r1, input logic [RW-1:0] r2);
    bus.rs1_valid = 1'b1;
    bus.rs1       = r1;
    bus.rs2_valid = 1'b1;
    bus.rs2       = r2;
  endtask

  task automatic stepCycle();
    @(posedge clk);
    @(negedge clk);
    applyStimulus();
  endtask

  initial begin
    checkCount = 0;
    passCount  = 0;
    applyStimulus();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    readSrc(5, 0);
    #1;
    checkOutput("reset Vj", 64'(bus.Vj), 64'h0);
    checkOutput("reset Vk", 64'(bus.Vk), 64'h0);
    checkOutput("reset Qj_valid", 64'(bus.Qj_valid), 64'h0);
    checkOutput("reset Qk_valid", 64'(bus.Qk_valid), 64'h0);
    checkOutput("reset rob_q1_tag", 64'(bus.rob_q1_tag), 64'h0);
    checkOutput("reset instret", bus.instret, 64'h0);

    setIssue(3, 2);
    stepCycle();
    readSrc(3, 0);
    #1;
    checkOutput("busy Qj_valid", 64'(bus.Qj_valid), 64'h1);
    checkOutput("busy Qj", 64'(bus.Qj), 64'h2);
    checkOutput("busy Vj", 64'(bus.Vj), 64'h0);
    checkOutput("busy rob_q1_tag", 64'(bus.rob_q1_tag), 64'h2);
    bus.rob_q1_ready = 1'b1;
    bus.rob_q1_value = 32'h55;
    #1;
    checkOutput("rob ready Vj", 64'(bus.Vj), 64'h55);
    checkOutput("rob ready Qj_valid", 64'(bus.Qj_valid), 64'h0);
    checkOutput("rob ready Qj", 64'(bus.Qj), 64'h0);

    bus.rob_q1_ready = 1'b0;
    setCommit(0, 3, 2, 32'hABCD);
    #1;
    checkOutput("bypass Vj", 64'(bus.Vj), 64'hABCD);
    checkOutput("bypass Qj_valid", 64'(bus.Qj_valid), 64'h0);
    stepCycle();
    readSrc(3, 0);
    #1;
    checkOutput("post commit Vj", 64'(bus.Vj), 64'hABCD);
    checkOutput("post commit Qj_valid", 64'(bus.Qj_valid), 64'h0);
    checkOutput("instret after 1", bus.instret, 64'd1);

    setIssue(4, 1);
    stepCycle();
    setCommit(0, 4, 1, 32'h44);
    setIssue(4, 6);
    stepCycle();
    readSrc(4, 0);
    #1;
    checkOutput("reissue Qj_valid", 64'(bus.Qj_valid), 64'h1);
    checkOutput("reissue Qj", 64'(bus.Qj), 64'h6);
    checkOutput("reissue Vj", 64'(bus.Vj), 64'h0);

    setCommit(0, 7, 0, 32'h11);
    setCommit(1, 7, 0, 32'h22);
    stepCycle();
    readSrc(7, 0);
    #1;
    checkOutput("dual lane Vj", 64'(bus.Vj), 64'h22);
    checkOutput("dual lane instret", bus.instret, 64'd4);

    setIssue(5, 3);
    stepCycle();
    setIssue(5, 4);
    stepCycle();
    setCommit(0, 5, 3, 32'h33);
    readSrc(5, 0);
    #1;
    checkOutput("stale no bypass Qj_valid", 64'(bus.Qj_valid), 64'h1);
    stepCycle();
    readSrc(5, 0);
    #1;
    checkOutput("stale Qj_valid", 64'(bus.Qj_valid), 64'h1);
    checkOutput("stale Qj", 64'(bus.Qj), 64'h4);
    checkOutput("stale instret", bus.instret, 64'd5);

    setIssue(3, 7);
    stepCycle();
    setIssue(9, 5);
    stepCycle();
    readSrc(3, 9);
    #1;
    checkOutput("pre flush Qj_valid", 64'(bus.Qj_valid), 64'h1);
    checkOutput("pre flush Qk", 64'(bus.Qk), 64'h5);
    bus.roll_back = 1'b1;
    setCommit(0, 9, 5, 32'h99);
    setIssue(10, 8);
    stepCycle();
    readSrc(3, 9);
    #1;
    checkOutput("flush Qj_valid", 64'(bus.Qj_valid), 64'h0);
    checkOutput("flush Vj reg3", 64'(bus.Vj), 64'hABCD);
    checkOutput("flush Qk_valid", 64'(bus.Qk_valid), 64'h0);
    checkOutput("flush Vk reg9", 64'(bus.Vk), 64'h99);
    checkOutput("flush instret", bus.instret, 64'd6);
    readSrc(10, 4);
    #1;
    checkOutput("flush issue ignored Qj_valid", 64'(bus.Qj_valid), 64'h0);
    checkOutput("flush issue ignored tag", 64'(bus.rob_q1_tag), 64'h0);
    checkOutput("flush Vk reg4", 64'(bus.Vk), 64'h44);
    readSrc(5, 0);
    #1;
    checkOutput("flush Vj reg5", 64'(bus.Vj), 64'h33);

    bus.rdy_in = 1'b0;
    setCommit(0, 9, 0, 32'hDEAD);
    setIssue(9, 2);
    stepCycle();
    readSrc(0, 9);
    #1;
    checkOutput("hold Vk", 64'(bus.Vk), 64'h99);
    checkOutput("hold Qk_valid", 64'(bus.Qk_valid), 64'h0);
    checkOutput("hold instret", bus.instret, 64'd6);

    setCommit(0, 0, 0, 32'hFF);
    stepCycle();
    readSrc(0, 0);
    #1;
    checkOutput("rd0 Vj", 64'(bus.Vj), 64'h0);
    checkOutput("rd0 instret", bus.instret, 64'd7);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end
endmodule

// File: doc/rename_regfile.md
# rename_regfile

Parametrised architectural register file with register alias state for the Tomasulo/ROB out-of-order core. It sits between the decoder/issue stage and the reservation stations and load/store buffer. For each issuing instruction it returns source operand values or producer ROB tags. On commit it updates architectural values from up to COMMIT_WIDTH in-order ROB lanes per cycle. Compared with the single-commit register file, it adds commit-to-read bypass, a ROB-ready value lookup for busy sources, correct commit handling during rollback, and a retired-instruction counter.

## Interface
- XLEN, 32, data width of a register
- REG_NUM, 32, number of architectural registers; index width RW = $clog2(REG_NUM)
- ENTRY_SIZE, 4, ROB tag width
- COMMIT_WIDTH, 2, commit lanes per cycle; lane 0 is oldest
- clk  in  1  clock; all state updates on the rising edge
- rst_in  in  1  synchronous, active-high reset
- rdy_in  in  1  global ready; when low, all state holds
- roll_back  in  1  misprediction flush
- issue_valid  in  1  an instruction with a destination issues this cycle
- issue_rd  in  RW  destination register
- issue_tag  in  ENTRY_SIZE  ROB entry allocated to the issuing instruction
- commit_valid  in  COMMIT_WIDTH  per-lane commit strobe
- commit_rd  in  COMMIT_WIDTH*RW  per-lane destination register (packed, lane 0 in the LSBs)
- commit_tag  in  COMMIT_WIDTH*ENTRY_SIZE  per-lane committing ROB entry
- commit_value  in  COMMIT_WIDTH*XLEN  per-lane result
- rs1_valid, rs2_valid  in  1 each  source operand is used
- rs1, rs2  in  RW each  source register indices
- rob_q1_tag, rob_q2_tag  out  ENTRY_SIZE each  ROB lookup tag (the current tag of rs1/rs2)
- rob_q1_ready, rob_q2_ready  in  1 each  that ROB entry has its result
- rob_q1_value, rob_q2_value  in  XLEN each  that ROB entry's result
- Qj_valid, Qk_valid  out  1 each  operand still pending
- Qj, Qk  out  ENTRY_SIZE each  producer tag; 0 when not pending
- Vj, Vk  out  XLEN each  operand value; 0 when pending
- instret  out  64  count of committed instructions

## Operation
- State per register: value[XLEN], tag[ENTRY_SIZE], busy. Register 0 always reads 0, is never made busy, and is never written.
- Read path (combinational, identical for rs1→j and rs2→k), first matching rule wins:
  - Source not valid, or index 0: V=0, Q_valid=0, Q=0.
  - The highest-numbered commit lane with commit_rd==rs, tag[rs]==that lane's commit_tag, and busy[rs]: V = that lane's commit_value, Q_valid=0.
  - busy[rs] and rob_qX_ready: V = rob_qX_value, Q_valid=0.
  - busy[rs]: Q_valid=1, Q=tag[rs], V=0.
  - Otherwise: V=value[rs], Q_valid=0.
- rob_qX_tag = tag[rs] at all times, regardless of busy.
- Sources read the state before this cycle's issue. An instruction with rd==rs1 sees the previous producer, not itself.
- Sequential update, in priority order:
  - rst_in: all value, tag and busy cleared; instret=0.
  - !rdy_in: hold all state.
  - roll_back: every valid commit lane writes its value to commit_rd (lanes in order, higher lane wins on the same rd). All busy bits and tags are cleared. Issue is ignored.
  - Normal:
    - Commit lanes are applied in order.
    - value[rd] ← commit_value.
    - busy/tag are cleared only if busy[rd] and tag[rd]==commit_tag.
    - Issue is applied last: tag[issue_rd] ← issue_tag and busy ← 1 when issue_rd≠0. Issue overrides a same-cycle commit clear on the same register.
- instret increases by popcount(commit_valid) whenever rdy_in is high and rst_in is low, including during roll_back.

## Timing
- Reads have zero latency. State writes become visible the cycle after the edge; the commit bypass covers same-cycle commits.
- Reset values: instret=0. With inputs low: Q*_valid=0, Q*=0, V*=0, rob_q*_tag=0.
- Commits with commit_rd==0 still count toward instret but write nothing.
- A commit whose tag is stale (register re-renamed) updates value but leaves busy/tag unchanged.
- instret wraps modulo 2^64.

## Test plan
- Reset, then read rs1=5, rs2=0 → Vj=0, Vk=0, Qj_valid=Qk_valid=0, instret=0.
- Issue rd=3 tag=2; next cycle read rs1=3 with rob_q1_ready=0 → Qj_valid=1, Qj=2, rob_q1_tag=2. With rob_q1_ready=1 and value 0x55 → Vj=0x55, Qj_valid=0.
- With reg 3 busy tag 2, commit lane0 rd=3 tag=2 value 0xABCD while reading rs1=3 → Vj=0xABCD the same cycle. Next cycle busy[3]=0 and value=0xABCD.
- Same cycle: commit rd=4 tag=1 (matching) and issue rd=4 tag=6 → next cycle Qj=6, Qj_valid=1, and value[4] holds the committed value.
- Both lanes commit rd=7 with values 0x11 then 0x22; the next read gives 0x22 and instret advances by 2.
- Registers 3 and 9 busy, roll_back with lane0 committing rd=9 value 0x99 → next cycle both are not busy, reg 9 reads 0x99, a same-cycle issue has no effect, and rdy_in=0 for the following cycle holds all state.
